// File: rtl/mat_slot_ctrl.sv
// Slot sequencer for the sparse-matrix datapath.
// Each slot admits one chaos parameter set and MAT_RANK source samples,
// then waits for MAT_RANK SpMV outputs before closing the slot.
// Also tracks the slot count for the run, and raises sticky overflow and
// timeout flags.
module mat_slot_ctrl #(
   parameter int SUBCAR_NUM   = 16,
   parameter int OFDM_SYM_NUM = 16,
   parameter int SLOT_CNT_W   = 16,
   parameter int TIMEOUT_CYC  = 4096
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  stop,
   input  logic [SLOT_CNT_W-1:0] cfg_slots,
   output logic                  busy,
   output logic                  slot_done,
   output logic [SLOT_CNT_W-1:0] slot_cnt,
   output logic [2:0]            state_o,
   output logic                  err_ovf,
   output logic                  err_tmo,
   input  logic                  chs_vld,
   output logic                  chs_rdy,
   output logic                  dp_rand_vld,
   input  logic                  dp_rand_rdy,
   input  logic                  src_vld,
   output logic                  src_rdy,
   output logic                  dp_src_vld,
   input  logic                  dp_src_rdy,
   input  logic                  dp_spmv_vld,
   input  logic                  dp_spmv_rdy
);

   localparam int MAT_RANK = SUBCAR_NUM * OFDM_SYM_NUM;
   localparam int CW       = $clog2(MAT_RANK + 1);
   localparam int TW       = $clog2(TIMEOUT_CYC);

   localparam logic [CW-1:0] RANK_C    = CW'(MAT_RANK);
   localparam logic [CW-1:0] LAST_IN_C = CW'(MAT_RANK - 1);
   // The timeout fires on the cycle whose increment would land on TIMEOUT_CYC-1.
   localparam logic [TW-1:0] TMO_PRE_C = TW'(TIMEOUT_CYC - 2);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PARAM = 3'd1,
      ST_LOAD  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   state_t                state_reg,     state_next;
   logic [CW-1:0]         in_cnt_reg,    in_cnt_next;
   logic [CW-1:0]         out_cnt_reg,   out_cnt_next;
   logic [TW-1:0]         tmo_cnt_reg,   tmo_cnt_next;
   logic [SLOT_CNT_W-1:0] slot_cnt_reg,  slot_cnt_next;
   logic                  stop_pend_reg, stop_pend_next;
   logic                  err_ovf_reg,   err_ovf_next;
   logic                  err_tmo_reg,   err_tmo_next;

   logic                  in_param;
   logic                  in_load;
   logic                  par_hs;
   logic                  src_hs;
   logic                  out_hs;
   logic [SLOT_CNT_W-1:0] slot_inc;

   // Zero-latency gating: each side only sees the other in its own state.
   assign in_param    = (state_reg == ST_PARAM);
   assign in_load     = (state_reg == ST_LOAD);
   assign dp_rand_vld = chs_vld & in_param;
   assign chs_rdy     = dp_rand_rdy & in_param;
   assign dp_src_vld  = src_vld & in_load;
   assign src_rdy     = dp_src_rdy & in_load;

   assign par_hs   = chs_vld & chs_rdy;
   assign src_hs   = src_vld & src_rdy;
   assign out_hs   = dp_spmv_vld & dp_spmv_rdy;
   assign slot_inc = slot_cnt_reg + 1'b1;

   assign busy      = (state_reg != ST_IDLE);
   assign slot_done = (state_reg == ST_DONE);
   assign slot_cnt  = slot_cnt_reg;
   assign state_o   = state_reg;
   assign err_ovf   = err_ovf_reg;
   assign err_tmo   = err_tmo_reg;

   // Next-state, counter and fault logic for the slot sequence.
   always_comb begin
      state_next     = state_reg;
      in_cnt_next    = in_cnt_reg;
      out_cnt_next   = out_cnt_reg;
      tmo_cnt_next   = tmo_cnt_reg;
      slot_cnt_next  = slot_cnt_reg;
      stop_pend_next = stop_pend_reg;
      err_ovf_next   = err_ovf_reg;
      err_tmo_next   = err_tmo_reg;

      // A stop request is remembered and acted on only at slot end.
      if (stop && (state_reg != ST_IDLE)) begin
         stop_pend_next = 1'b1;
      end

      // Outputs may overlap input, so they are counted in LOAD as well as DRAIN.
      if (out_hs && (state_reg == ST_LOAD || state_reg == ST_DRAIN || state_reg == ST_DONE)) begin
         if (out_cnt_reg == RANK_C) begin
            err_ovf_next = 1'b1;
         end else if (state_reg != ST_DONE) begin
            out_cnt_next = out_cnt_reg + 1'b1;
         end
      end

      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               slot_cnt_next  = '0;
               err_ovf_next   = 1'b0;
               err_tmo_next   = 1'b0;
               stop_pend_next = 1'b0;
               state_next     = ST_PARAM;
            end
         end
         ST_PARAM: begin
            in_cnt_next  = '0;
            out_cnt_next = '0;
            tmo_cnt_next = '0;
            if (par_hs) begin
               state_next = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (src_hs) begin
               in_cnt_next = in_cnt_reg + 1'b1;
               if (in_cnt_reg == LAST_IN_C) begin
                  state_next = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (out_cnt_reg == RANK_C) begin
               state_next = ST_DONE;
            end else if (out_hs) begin
               tmo_cnt_next = '0;
            end else begin
               tmo_cnt_next = tmo_cnt_reg + 1'b1;
               if (tmo_cnt_reg == TMO_PRE_C) begin
                  err_tmo_next = 1'b1;
                  state_next   = ST_IDLE;
               end
            end
         end
         ST_DONE: begin
            slot_cnt_next = slot_inc;
            if (stop_pend_reg || ((cfg_slots != '0) && (slot_inc == cfg_slots))) begin
               state_next = ST_IDLE;
            end else begin
               state_next = ST_PARAM;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // State and counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         in_cnt_reg    <= '0;
         out_cnt_reg   <= '0;
         tmo_cnt_reg   <= '0;
         slot_cnt_reg  <= '0;
         stop_pend_reg <= 1'b0;
         err_ovf_reg   <= 1'b0;
         err_tmo_reg   <= 1'b0;
      end else begin
         state_reg     <= state_next;
         in_cnt_reg    <= in_cnt_next;
         out_cnt_reg   <= out_cnt_next;
         tmo_cnt_reg   <= tmo_cnt_next;
         slot_cnt_reg  <= slot_cnt_next;
         stop_pend_reg <= stop_pend_next;
         err_ovf_reg   <= err_ovf_next;
         err_tmo_reg   <= err_tmo_next;
      end
   end

endmodule
